// File: rtl/keyboard_pkg.sv
// Shared constants for the keyboard note scheduler: note period table, FSM states, widths.
package keyboard_pkg;

  localparam int RATE_W     = 17;
  localparam int INC_W      = 5;
  localparam int KEY_IDX_W  = 3;
  localparam int NOTE_COUNT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    PLAY,
    FADE
  } state_t;

  // CLOCK_50 cycles per period, C5 through C6
  localparam logic [RATE_W-1:0] NOTE_RATE [0:NOTE_COUNT-1] = '{
    17'd95556, 17'd85131, 17'd75843, 17'd71586,
    17'd63776, 17'd56818, 17'd50619, 17'd47778
  };

  function automatic logic [KEY_IDX_W-1:0] highest_index(input logic [NOTE_COUNT-1:0] v);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NOTE_COUNT; i++) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One-key debouncer: 2-FF synchroniser, then the level flips only after DEB_CYCLES
// consecutive synchronised samples that disagree with it.
module key_debouncer #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_reg, sync2_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      level     <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
        cnt_reg <= '0;
        level   <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Keyboard-to-codec note scheduler: debounce, last-press arbitration, muted note switching.
// Optional feature macro: OCTAVE_SHIFT_EN (adds OCT_UP/OCT_DN octave shift of INCREMENTO_AUDIO).
module note_scheduler
  import keyboard_pkg::*;
#(
  parameter int NUM_KEYS    = 8,
  parameter int DEB_CYCLES  = 500000,
  parameter int MUTE_CYCLES = 1024
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [NUM_KEYS-1:0]  KEYS,
`ifdef OCTAVE_SHIFT_EN
  input  logic                 OCT_UP,
  input  logic                 OCT_DN,
`endif
  output logic [RATE_W-1:0]    TAXA_AMOSTRAGEM,
  output logic [INC_W-1:0]     INCREMENTO_AUDIO,
  output logic                 AUDIO_MUTE,
  output logic                 NOTE_ACTIVE,
  output logic [KEY_IDX_W-1:0] ACTIVE_KEY
);

  localparam int CNT_W = $clog2(MUTE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUTE_CYCLES - 1);

  logic [NUM_KEYS-1:0]  deb_level, deb_prev_reg, press_vec, other_press;
  logic                 press_any, held_any;
  logic [KEY_IDX_W-1:0] press_idx, held_idx, sel;
  logic [INC_W-1:0]     load_inc;

  state_t               state_reg, state_next;
  logic [KEY_IDX_W-1:0] target_reg, target_next, key_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [RATE_W-1:0]    rate_next;
  logic [INC_W-1:0]     inc_next;
  logic                 mute_next, active_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .raw   (KEYS[gi]),
        .level (deb_level[gi])
      );
    end
  endgenerate

`ifdef OCTAVE_SHIFT_EN
  logic [1:0] oct_level, oct_prev_reg;
  logic [2:0] shift_reg, shift_next;
  logic       up_press, dn_press;

  key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(CLOCK_50), .rst(RESET), .raw(OCT_UP), .level(oct_level[0]));
  key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk(CLOCK_50), .rst(RESET), .raw(OCT_DN), .level(oct_level[1]));

  always_comb begin
    up_press   = oct_level[0] & ~oct_prev_reg[0];
    dn_press   = oct_level[1] & ~oct_prev_reg[1];
    shift_next = shift_reg;
    if (up_press && !dn_press && shift_reg != 3'd4)
      shift_next = shift_reg + 3'd1;
    else if (dn_press && !up_press && shift_reg != 3'd0)
      shift_next = shift_reg - 3'd1;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      oct_prev_reg <= '0;
      shift_reg    <= '0;
    end else begin
      oct_prev_reg <= oct_level;
      shift_reg    <= shift_next;
    end
  end

  assign load_inc = INC_W'(1) << shift_reg;
`else
  assign load_inc = INC_W'(1);
`endif

  always_comb begin
    press_vec   = deb_level & ~deb_prev_reg;
    press_any   = |press_vec;
    held_any    = |deb_level;
    press_idx   = highest_index(press_vec);
    held_idx    = highest_index(deb_level);
    other_press = press_vec & ~(NUM_KEYS'(1) << ACTIVE_KEY);
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    cnt_next    = cnt_reg;
    rate_next   = TAXA_AMOSTRAGEM;
    inc_next    = INCREMENTO_AUDIO;
    mute_next   = AUDIO_MUTE;
    active_next = NOTE_ACTIVE;
    key_next    = ACTIVE_KEY;
    sel         = target_reg;
    case (state_reg)
      IDLE: begin
        mute_next   = 1'b1;
        active_next = 1'b0;
        if (press_any) begin
          target_next = press_idx;
          cnt_next    = '0;
          state_next  = SWITCH;
        end
      end
      SWITCH: begin
        mute_next   = 1'b1;
        active_next = 1'b0;
        if (press_any)
          sel = press_idx;
        else if (!deb_level[target_reg])
          sel = held_idx;
        target_next = sel;
        // target gone and nothing else held: abandon the switch
        if (!press_any && !deb_level[target_reg] && !held_any) begin
          state_next = FADE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          rate_next   = NOTE_RATE[sel];
          key_next    = sel;
          inc_next    = load_inc;
          mute_next   = 1'b0;
          active_next = 1'b1;
          state_next  = PLAY;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PLAY: begin
        if (|other_press) begin
          target_next = highest_index(other_press);
          cnt_next    = '0;
          mute_next   = 1'b1;
          active_next = 1'b0;
          state_next  = SWITCH;
        end else if (!deb_level[ACTIVE_KEY]) begin
          target_next = held_idx;
          cnt_next    = '0;
          mute_next   = 1'b1;
          active_next = 1'b0;
          state_next  = held_any ? SWITCH : FADE;
        end
      end
      FADE: begin
        mute_next   = 1'b1;
        active_next = 1'b0;
        if (press_any) begin
          target_next = press_idx;
          cnt_next    = '0;
          state_next  = SWITCH;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_reg        <= IDLE;
      target_reg       <= '0;
      cnt_reg          <= '0;
      deb_prev_reg     <= '0;
      TAXA_AMOSTRAGEM  <= NOTE_RATE[0];
      INCREMENTO_AUDIO <= INC_W'(1);
      AUDIO_MUTE       <= 1'b1;
      NOTE_ACTIVE      <= 1'b0;
      ACTIVE_KEY       <= '0;
    end else begin
      state_reg        <= state_next;
      target_reg       <= target_next;
      cnt_reg          <= cnt_next;
      deb_prev_reg     <= deb_level;
      TAXA_AMOSTRAGEM  <= rate_next;
      INCREMENTO_AUDIO <= inc_next;
      AUDIO_MUTE       <= mute_next;
      NOTE_ACTIVE      <= active_next;
      ACTIVE_KEY       <= key_next;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with DEB_CYCLES=16, MUTE_CYCLES=8.
// A key raised at a negedge is debounced at the 18th following posedge.
module tb_note_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  keys = 8'h00;
  logic [16:0] taxa;
  logic [4:0]  inc;
  logic        mute, nact;
  logic [2:0]  akey;
`ifdef OCTAVE_SHIFT_EN
  logic        oct_up = 1'b0;
  logic        oct_dn = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  note_scheduler #(.NUM_KEYS(8), .DEB_CYCLES(16), .MUTE_CYCLES(8)) dut (
    .CLOCK_50         (clk),
    .RESET            (rst),
    .KEYS             (keys),
`ifdef OCTAVE_SHIFT_EN
    .OCT_UP           (oct_up),
    .OCT_DN           (oct_dn),
`endif
    .TAXA_AMOSTRAGEM  (taxa),
    .INCREMENTO_AUDIO (inc),
    .AUDIO_MUTE       (mute),
    .NOTE_ACTIVE      (nact),
    .ACTIVE_KEY       (akey)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // 1: reset held with all keys down
    keys = 8'hFF;
    step(3);
    check_eq("rst_mute", 32'(mute), 32'd1);
    check_eq("rst_taxa", 32'(taxa), 32'd95556);
    check_eq("rst_inc",  32'(inc),  32'd1);
    check_eq("rst_nact", 32'(nact), 32'd0);
    check_eq("rst_key",  32'(akey), 32'd0);
    keys = 8'h00;
    step(1);
    rst = 1'b0;
    step(2);

    // 2: 10-cycle glitch is rejected, then a real press
    keys = 8'h04;
    step(10);
    keys = 8'h00;
    step(25);
    check_eq("glitch_mute", 32'(mute), 32'd1);
    check_eq("glitch_nact", 32'(nact), 32'd0);
    keys = 8'h04;
    step(26);
    check_eq("k2_mute_before", 32'(mute), 32'd1);
    step(1);
    check_eq("k2_mute", 32'(mute), 32'd0);
    check_eq("k2_taxa", 32'(taxa), 32'd75843);
    check_eq("k2_key",  32'(akey), 32'd2);
    check_eq("k2_nact", 32'(nact), 32'd1);
    check_eq("k2_inc",  32'(inc),  32'd1);

    // 3: press key5 over held key2, then release key5
    keys = 8'h24;
    step(19);
    check_eq("k5_switch_mute", 32'(mute), 32'd1);
    check_eq("k5_switch_taxa", 32'(taxa), 32'd75843);
    step(8);
    check_eq("k5_taxa", 32'(taxa), 32'd56818);
    check_eq("k5_key",  32'(akey), 32'd5);
    check_eq("k5_mute", 32'(mute), 32'd0);
    keys = 8'h04;
    step(19);
    check_eq("back2_switch_mute", 32'(mute), 32'd1);
    check_eq("back2_switch_taxa", 32'(taxa), 32'd56818);
    step(8);
    check_eq("back2_taxa", 32'(taxa), 32'd75843);
    check_eq("back2_key",  32'(akey), 32'd2);

    // 4a: keys 1 and 6 debounced in the same cycle
    keys = 8'h42;
    step(27);
    check_eq("k16_key",  32'(akey), 32'd6);
    check_eq("k16_taxa", 32'(taxa), 32'd50619);
    check_eq("k16_mute", 32'(mute), 32'd0);

    // 5: release all, press key3 while fading
    keys = 8'h00;
    step(5);
    keys = 8'h08;
    step(14);
    check_eq("fade_mute", 32'(mute), 32'd1);
    check_eq("fade_nact", 32'(nact), 32'd0);
    check_eq("fade_taxa", 32'(taxa), 32'd50619);
    check_eq("fade_key",  32'(akey), 32'd6);
    step(12);
    check_eq("k3_pre_mute", 32'(mute), 32'd1);
    step(1);
    check_eq("k3_taxa", 32'(taxa), 32'd71586);
    check_eq("k3_key",  32'(akey), 32'd3);
    check_eq("k3_mute", 32'(mute), 32'd0);

    // 4b: release all, fade runs out into idle, rate held
    keys = 8'h00;
    step(19);
    check_eq("rel_mute", 32'(mute), 32'd1);
    step(12);
    check_eq("idle_mute", 32'(mute), 32'd1);
    check_eq("idle_nact", 32'(nact), 32'd0);
    check_eq("idle_taxa", 32'(taxa), 32'd71586);
    check_eq("idle_key",  32'(akey), 32'd3);

    // 5b: reset during SWITCH, debounce restarts from scratch
    keys = 8'h80;
    step(20);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_mute", 32'(mute), 32'd1);
    check_eq("mid_rst_taxa", 32'(taxa), 32'd95556);
    check_eq("mid_rst_key",  32'(akey), 32'd0);
    check_eq("mid_rst_nact", 32'(nact), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(26);
    check_eq("k7_pre_mute", 32'(mute), 32'd1);
    step(1);
    check_eq("k7_mute", 32'(mute), 32'd0);
    check_eq("k7_taxa", 32'(taxa), 32'd47778);
    check_eq("k7_key",  32'(akey), 32'd7);

`ifdef OCTAVE_SHIFT_EN
    // 6: octave shift saturates at 4, applied only at the next load
    repeat (6) begin
      oct_up = 1'b1;
      step(20);
      oct_up = 1'b0;
      step(20);
    end
    check_eq("oct_hold_inc", 32'(inc), 32'd1);
    keys = 8'h88;
    step(27);
    check_eq("oct_up_inc", 32'(inc),  32'd16);
    check_eq("oct_up_key", 32'(akey), 32'd3);
    oct_dn = 1'b1;
    step(20);
    oct_dn = 1'b0;
    step(20);
    check_eq("oct_dn_hold", 32'(inc), 32'd16);
    keys = 8'h80;
    step(27);
    check_eq("oct_dn_inc", 32'(inc),  32'd8);
    check_eq("oct_dn_key", 32'(akey), 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
